multdiv_seq: RTL and testbench

- Iterative signed 32-bit multiply/divide unit.
- Sits beside the execute stage of the 5-stage pipeline and consumes the execute-stage bypassed operands.
- Started by a one-cycle pulse. Runs for a fixed number of cycles, then returns the result with a one-cycle ready pulse.
- The pipeline stalls PC and all latches until ready rises, then latches data_result/data_exception into X/M.

---
 rtl/multdiv_seq_pkg.sv | 14 +
 rtl/twos_negate.sv | 17 +
 rtl/multdiv_seq.sv | 160 ++++++++++++++++
 tb/tb_multdiv_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_seq_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit.
package multdiv_seq_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam logic [31:0] IntMin       = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and the result sign fix.
module twos_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg_en,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in;
        if (neg_en) begin
            out = ~in + 1'b1;
        end
    end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide: one bit per cycle on operand magnitudes, sign fixed at the end.
module multdiv_seq
    import multdiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

    state_e state_q, state_d;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] opnd_q, hi_q, lo_q, hi_d, lo_d;
    logic             sign_q, op_div_q, b_zero_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d, rdy_q;
    logic             start, step, finish;
    logic [WIDTH-1:0] abs_a, abs_b, res_signed;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;

    assign start = ctrl_MULT | ctrl_DIV;

    twos_negate #(.WIDTH(WIDTH)) u_abs_a (
        .in     (data_operandA),
        .neg_en (data_operandA[WIDTH-1]),
        .out    (abs_a)
    );

    twos_negate #(.WIDTH(WIDTH)) u_abs_b (
        .in     (data_operandB),
        .neg_en (data_operandB[WIDTH-1]),
        .out    (abs_b)
    );

    twos_negate #(.WIDTH(WIDTH)) u_res_fix (
        .in     (lo_q),
        .neg_en (sign_q),
        .out    (res_signed)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a new start always wins, aborting whatever is in flight
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ctrl_MULT ? StMul : StDiv;
        end else begin
            case (state_q)
                StMul, StDiv: if (cnt_q == LastCnt) state_d = StDone;
                StDone:       state_d = StIdle;
                default:      state_d = StIdle;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        step   = 1'b0;
        finish = 1'b0;
        if (!start) begin
            step   = (state_q == StMul) || (state_q == StDiv);
            finish = (state_q == StDone);
        end
    end

    // One iteration of shift-add (multiply) or restoring subtract (divide)
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (state_q == StDiv) begin
            if (!div_diff[WIDTH]) begin
                hi_d = div_diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Multiply: {hi,lo} is the magnitude product; negative results may reach -2^(WIDTH-1).
    // Divide: lo is the quotient magnitude; only INT_MIN / -1 overflows positive.
    always_comb begin
        result_d = res_signed;
        if (op_div_q) begin
            exc_d = b_zero_q | (~sign_q & lo_q[WIDTH-1]);
            if (b_zero_q) begin
                result_d = '0;
            end
        end else begin
            exc_d = (hi_q != '0) | (sign_q ? (lo_q > MinVal) : lo_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sign_q   <= 1'b0;
            op_div_q <= 1'b0;
            b_zero_q <= 1'b0;
        end else if (start) begin
            cnt_q    <= '0;
            opnd_q   <= ctrl_MULT ? abs_a : abs_b;
            lo_q     <= ctrl_MULT ? abs_b : abs_a;
            hi_q     <= '0;
            sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            op_div_q <= ~ctrl_MULT;
            b_zero_q <= (data_operandB == '0);
        end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= finish;
            if (finish) begin
                result_q <= result_d;
                exc_q    <= exc_d;
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: scoreboard of expected results, latency and abort checks.
module tb_multdiv_seq;
    import multdiv_seq_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    multdiv_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic mul, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        logic [63:0] pv;
        int          q;
        if (mul) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            pv    = p;
            e.res = pv[31:0];
            e.exc = (p != longint'($signed(pv[31:0])));
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else if (a == IntMin && b == 32'hFFFF_FFFF) begin
            e.res = IntMin;
            e.exc = 1'b1;
        end else begin
            q     = $signed(a) / $signed(b);
            e.res = q;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Pulse a start at the next rising edge; any pending op is aborted so its entry is dropped.
    task automatic start_op(input logic mul, input logic div, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        sb.delete();
        sb.push_back(model(mul, a, b));
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Count edges after the start edge until ready; lat = -1 on timeout.
    task automatic wait_done(output int lat, output logic [31:0] res, output logic exc,
                             output logic fell);
        lat  = -1;
        res  = 'x;
        exc  = 1'bx;
        fell = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = n;
                res = data_result;
                exc = data_exception;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clock);
            #1;
            fell = !data_resultRDY;
        end
    endtask

    task automatic test_reset();
        int pulses;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (data_result !== 32'd0) begin
            failures++;
            $display("FAIL reset_result: got %h want 00000000", data_result);
        end
        checks++;
        if (data_exception !== 1'b0) begin
            failures++;
            $display("FAIL reset_exc: got %b want 0", data_exception);
        end
        checks++;
        if (data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdy: got %b want 0", data_resultRDY);
        end
        @(negedge clock);
        reset  = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL idle_rdy: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_ops(input logic mul, input string tag, input logic [31:0] av[],
                            input logic [31:0] bv[]);
        int          lat;
        logic [31:0] res;
        logic        exc, fell;
        exp_t        e;
        for (int i = 0; i < av.size(); i++) begin
            start_op(mul, !mul, av[i], bv[i]);
            wait_done(lat, res, exc, fell);
            e = sb.pop_front();
            checks++;
            if (lat !== 33) begin
                failures++;
                $display("FAIL %s_latency[%0d]: got %0d want 33", tag, i, lat);
            end
            checks++;
            if (res !== e.res) begin
                failures++;
                $display("FAIL %s_result[%0d] a=%h b=%h: got %h want %h", tag, i, av[i], bv[i],
                         res, e.res);
            end
            checks++;
            if (exc !== e.exc) begin
                failures++;
                $display("FAIL %s_exc[%0d] a=%h b=%h: got %b want %b", tag, i, av[i], bv[i],
                         exc, e.exc);
            end
            checks++;
            if (fell !== 1'b1) begin
                failures++;
                $display("FAIL %s_rdy_pulse[%0d]: got fell=%b want 1", tag, i, fell);
            end
        end
    endtask

    task automatic test_mult();
        logic [31:0] av[] = '{32'd7, 32'h0001_0000, 32'hFFFF_0000, 32'd0, 32'd0, 32'd0};
        logic [31:0] bv[] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'h0000_8000, 32'd0, 32'd0, 32'd0};
        for (int i = 3; i < 6; i++) begin
            av[i] = $urandom;
            bv[i] = 32'($urandom_range(0, 200)) - 32'd100;
        end
        test_ops(1'b1, "mult", av, bv);
    endtask

    task automatic test_div();
        logic [31:0] av[] = '{32'hFFFF_FFD3, 32'd45, 32'd5, 32'h8000_0000, 32'd0, 32'd0, 32'd0};
        logic [31:0] bv[] = '{32'd7, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
        for (int i = 4; i < 7; i++) begin
            av[i] = $urandom;
            bv[i] = 32'($urandom_range(1, 5000)) - 32'd2500;
        end
        test_div_hook: test_ops(1'b0, "div", av, bv);
    endtask

    task automatic test_abort();
        int          lat, pulses;
        logic [31:0] res;
        logic        exc, fell;
        exp_t        e;
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        pulses = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        start_op(1'b0, 1'b1, 32'd100, 32'd9);
        wait_done(lat, res, exc, fell);
        e = sb.pop_front();
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL abort_early_rdy: got %0d pulses want 0", pulses);
        end
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL abort_latency: got %0d want 33 (edge 43)", lat);
        end
        checks++;
        if (res !== e.res || exc !== e.exc) begin
            failures++;
            $display("FAIL abort_result: got %h/%b want %h/%b", res, exc, e.res, e.exc);
        end
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        wait_done(lat, res, exc, fell);
        e = sb.pop_front();
        checks++;
        if (lat !== 33 || res !== e.res || exc !== e.exc) begin
            failures++;
            $display("FAIL both_priority: got lat=%0d %h/%b want lat=33 %h/%b", lat, res, exc,
                     e.res, e.exc);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] res, prev;
        logic        exc, fell, prev_exc;
        exp_t        e;
        start_op(1'b1, 1'b0, 32'hFFFF_FFF0, 32'd1000);
        wait_done(lat, res, exc, fell);
        e        = sb.pop_front();
        prev     = e.res;
        prev_exc = e.exc;
        start_op(1'b0, 1'b1, 32'd1000, 32'd7);
        checks++;
        if (data_result !== prev || data_exception !== prev_exc) begin
            failures++;
            $display("FAIL hold_at_start: got %h/%b want %h/%b", data_result, data_exception,
                     prev, prev_exc);
        end
        wait_done(lat, res, exc, fell);
        e = sb.pop_front();
        checks++;
        if (lat !== 33 || res !== e.res || exc !== e.exc) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d %h/%b want lat=33 %h/%b", lat, res, exc,
                     e.res, e.exc);
        end
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (data_result !== e.res || data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL hold_after: got %h rdy=%b want %h rdy=0", data_result, data_resultRDY,
                     e.res);
        end
    endtask

    task automatic test_reset_mid_op();
        int          lat, pulses;
        logic [31:0] res;
        logic        exc, fell;
        exp_t        e;
        start_op(1'b0, 1'b1, 32'd100, 32'd9);
        repeat (14) @(posedge clock);
        @(posedge clock);
        reset = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %h/%b rdy=%b want 0/0 rdy=0", data_result,
                     data_exception, data_resultRDY);
        end
        @(negedge clock);
        reset  = 1'b1;
        pulses = 0;
        repeat (45) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL reset_mid_stray_rdy: got %0d pulses want 0", pulses);
        end
        start_op(1'b1, 1'b0, 32'd2, 32'd3);
        wait_done(lat, res, exc, fell);
        e = sb.pop_front();
        checks++;
        if (lat !== 33 || res !== e.res || exc !== e.exc) begin
            failures++;
            $display("FAIL reset_mid_recover: got lat=%0d %h/%b want lat=33 %h/%b", lat, res, exc,
                     e.res, e.exc);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_abort();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
